// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM port scheduler: default geometry and the
// return-tag encoding that follows each access down the read pipe.
package vram_pkg;

  localparam int VRAM_ADDR_W = 17;  // 320x240 words
  localparam int VRAM_DATA_W = 12;  // RGB444
  localparam int VRAM_DIV    = 4;   // clk cycles per pixel slot (3..16)

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_RD   = 2'd2
  } tag_e;

endpackage

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Port 0 is the game write port, port 1 the
// game read port. The pointer moves to the other port after every grant,
// so two continuous requesters are served strictly alternately.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  logic ptr;  // 0: port 0 wins a tie, 1: port 1 wins a tie

  // Grant selection: single eligible port wins outright, a tie goes to ptr
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (elig == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else               grant = elig;
    end
  end

  // Pointer register: hand priority to the port that did not just win
  always_ff @(posedge clk) begin
    if (rst)           ptr <= 1'b0;
    else if (grant[0]) ptr <= 1'b1;
    else if (grant[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slot scheduler for the shared frame/sprite BRAM port. Each pixel slot
// is DIV clk cycles: the access presented in phase 0 is always the VGA fetch,
// phases 1..DIV-1 are shared round-robin between game write and game read.
// pix_tick replaces the old divided pixel clock with a clock enable.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DIV    = VRAM_DIV
) (
  input  logic              clk,
  input  logic              rst,
  output logic              pix_tick,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              PH_W = $clog2(DIV);
  localparam logic [PH_W-1:0] LAST = PH_W'(DIV - 1);

  logic [PH_W-1:0] phase;
  logic            vga_slot;
  logic [1:0]      elig;
  logic [1:0]      grant;
  tag_e            mem_tag;   // kind of access currently on mem_*
  tag_e            ret_tag;   // kind of access whose data is on mem_rdata

  // The decision taken in the last phase lands in phase 0: reserved for VGA
  assign vga_slot = (phase == LAST);
  // A port is not eligible in its own ack cycle, so the requester can drop
  // or refresh its request before it can be granted again.
  assign elig     = {rd_req & ~rd_ack, wr_req & ~wr_ack};
  assign pix_tick = (phase == '0) & ~rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (~vga_slot),
    .elig  (elig),
    .grant (grant)
  );

  // Slot phase counter, 0..DIV-1
  always_ff @(posedge clk) begin
    if (rst)           phase <= '0;
    else if (vga_slot) phase <= '0;
    else               phase <= phase + PH_W'(1);
  end

  // Registered memory bus: present the access decided in the previous cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      mem_tag   <= TAG_NONE;
    end else begin
      wr_ack  <= grant[0];
      rd_ack  <= grant[1];
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      mem_tag <= TAG_NONE;
      if (vga_slot) begin
        mem_en   <= 1'b1;
        mem_addr <= vga_addr;
        mem_tag  <= TAG_VGA;
      end else if (grant[0]) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (grant[1]) begin
        mem_en   <= 1'b1;
        mem_addr <= rd_addr;
        mem_tag  <= TAG_RD;
      end
    end
  end

  // Read return: capture BRAM data one cycle after presentation and steer it
  // by tag, so a game read in the last phase cannot collide with the VGA word
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_tag   <= TAG_NONE;
      vga_valid <= 1'b0;
      rd_valid  <= 1'b0;
      vga_data  <= '0;
      rd_data   <= '0;
    end else begin
      ret_tag   <= mem_tag;
      vga_valid <= (ret_tag == TAG_VGA);
      rd_valid  <= (ret_tag == TAG_RD);
      if (ret_tag == TAG_VGA) vga_data <= mem_rdata;
      if (ret_tag == TAG_RD)  rd_data  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter (DIV=4). Expected read data comes from a fixed
// memory content function; expectations are queued when a fetch or read is
// issued and popped by the monitor whenever a valid pulse appears.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_tick;
  logic [16:0] vga_addr = 17'h00123;
  logic [11:0] vga_data;
  logic        vga_valid;
  logic        wr_req = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [16:0] rd_addr = '0;
  logic        rd_ack;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;

  vram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .pix_tick  (pix_tick),
    .vga_addr  (vga_addr),
    .vga_data  (vga_data),
    .vga_valid (vga_valid),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    int unsigned c;
  } rd_exp_t;

  logic [11:0] vga_q[$];
  rd_exp_t     rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned tb_cyc;
  logic [1:0]  ph;
  logic [16:0] vga_addr_q;
  logic        prev_wr, prev_rd;

  assign ph = tb_cyc[1:0];

  function automatic logic [11:0] model(input logic [16:0] a);
    case (a)
      17'h00123: return 12'hABC;
      17'h00020: return 12'h3C3;
      default:   return a[11:0] ^ 12'hFFF;
    endcase
  endfunction

  // Cycle index since reset release; phase is its low two bits
  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
    vga_addr_q <= vga_addr;
  end

  // BRAM model: 1-cycle read latency, zeros when not reading
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? model(mem_addr) : 12'h000;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each phase-3 cycle issues a VGA fetch of the driven address
  task automatic vga_pusher();
    forever begin
      @(posedge clk);
      if (!rst && ph == 2'd3) vga_q.push_back(model(vga_addr));
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        vga_q.delete();
        rd_q.delete();
        prev_wr = 1'b0;
        prev_rd = 1'b0;
      end else begin
        check("pix_tick", pix_tick, ph == 2'd0);
        check("vga_valid", vga_valid, (ph == 2'd2) && (tb_cyc >= 6));
        if (vga_valid) begin
          if (vga_q.size() == 0) check("vga_valid_unexpected", 1, 0);
          else check("vga_data", vga_data, vga_q.pop_front());
        end
        check("mem_en", mem_en, ((ph == 2'd0) && (tb_cyc >= 4)) || wr_ack || rd_ack);
        check("mem_we", mem_we, wr_ack);
        check("both_acks", wr_ack && rd_ack, 0);
        if (ph == 2'd0 && tb_cyc >= 4) check("vga_mem_addr", mem_addr, vga_addr_q);
        if (wr_ack) begin
          check("wr_mem_addr", mem_addr, wr_addr);
          check("wr_mem_wdata", mem_wdata, wr_data);
          check("wr_ack_phase0", ph == 2'd0, 0);
          check("wr_ack_adjacent", prev_wr, 0);
        end
        if (rd_ack) begin
          check("rd_mem_addr", mem_addr, rd_addr);
          check("rd_ack_phase0", ph == 2'd0, 0);
          check("rd_ack_adjacent", prev_rd, 0);
        end
        if (rd_valid) begin
          if (rd_q.size() == 0) check("rd_valid_unexpected", 1, 0);
          else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            check("rd_data", rd_data, e.d);
            check("rd_valid_cycle", tb_cyc, e.c);
          end
        end
        prev_wr = wr_ack;
        prev_rd = rd_ack;
      end
    end
  endtask

  // Advance one cycle; an observed read ack issues its expected return
  task automatic step();
    @(negedge clk);
    if (!rst && rd_ack) rd_q.push_back('{d: model(rd_addr), c: tb_cyc + 2});
  endtask

  function automatic logic [63:0] outs();
    return {4'h0, pix_tick, vga_valid, vga_data, wr_ack, rd_ack, rd_data, rd_valid,
            mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  // rst high for three cycles; outputs checked once reset has been clocked in
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); check("rst_outputs_a", outs(), 64'h0);
    @(negedge clk); check("rst_outputs_b", outs(), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_read(input logic [16:0] a, input bit align, output int ack_ph);
    if (align) begin
      for (int k = 0; k < 8; k++) begin
        step();
        if (ph == 2'd1) break;
      end
    end
    @(posedge clk); #1;
    rd_addr = a;
    rd_req  = 1'b1;
    ack_ph  = -1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (rd_ack) begin
        ack_ph = int'(ph);
        break;
      end
    end
    if (ack_ph < 0) check("rd_ack_timeout", 1, 0);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  initial begin
    int n, nw, nr, last, kind, aph;
    bit got;
    fork
      monitor();
      vga_pusher();
    join_none

    // Reset, then VGA-only traffic on two addresses
    do_reset();
    repeat (24) step();
    @(posedge clk); #1; vga_addr = 17'h00456;
    repeat (16) step();
    @(posedge clk); #1; vga_addr = 17'h00123;
    repeat (8) step();

    // Single write requester held: steady state is one ack at phases 1 and 3
    @(posedge clk); #1;
    wr_addr = 17'h00010;
    wr_data = 12'h5A5;
    wr_req  = 1'b1;
    repeat (4) step();
    n = 0;
    repeat (40) begin
      step();
      if (wr_ack) n++;
    end
    check("wr_ack_rate", n, 20);
    @(posedge clk); #1; wr_req = 1'b0;
    repeat (4) step();

    // Contention for 100 slots straight out of reset
    rd_addr = 17'h00020;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    do_reset();
    nw = 0; nr = 0; last = 0;
    for (int i = 0; i < 402; i++) begin
      step();
      if (wr_ack || rd_ack) begin
        kind = wr_ack ? 1 : 2;
        if (last == 0) check("first_grant_wr", kind, 1);
        else           check("grant_alternate", kind, (last == 1) ? 2 : 1);
        last = kind;
        if (wr_ack) nw++;
        if (rd_ack) nr++;
      end
      if (i == 399) begin
        @(posedge clk); #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
    end
    check("grant_total", nw + nr, 300);
    check("wr_grants", nw, 150);
    check("rd_grants", nr, 150);
    repeat (4) step();

    // Read acked at phase 3 overlaps the next VGA fetch; then an unaligned read
    do_read(17'h00020, 1'b1, aph);
    check("rd_ack_phase3", aph, 3);
    repeat (8) step();
    do_read(17'h00456, 1'b0, aph);
    repeat (8) step();

    // rst one cycle after rd_ack: the read must never return
    do_read(17'h00020, 1'b0, aph);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", outs() & ~(64'h1 << 59), 64'h0);
    check("post_rst_pix_tick", pix_tick, 1);
    repeat (8) step();

    // Last grant to wr leaves priority with rd; reset must restore wr priority
    @(posedge clk); #1;
    wr_addr = 17'h1FFFF;
    wr_data = 12'h0F0;
    wr_req  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("wr_ack_timeout", 1, 0);
    @(posedge clk); #1;
    rst    = 1'b1;
    rd_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (wr_ack || rd_ack) begin
        check("ptr_reset_first_wr", {wr_ack, rd_ack}, 2'b10);
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ptr_reset_timeout", 1, 0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (8) step();

    check("rd_queue_drained", rd_q.size(), 0);
    check("vga_queue_bounded", vga_q.size() <= 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
